led_scanner: RTL and testbench
==============================

# led_scanner

Time-multiplexing scan controller for the 4-digit seven-segment display path. It sits directly upstream of the nibble selector, segment encoder and digit splitter, and drives their `num`, `digit` and `dot` inputs. It double-buffers a 16-bit hex value and 4 dot bits and steps through digits at a fixed slot rate. It also adds an anti-ghosting blank window and leading-zero suppression.

## Interface
- `PRESCALE`, default 1000: clock cycles per digit slot; legal range 2..65535.
- `BLANK`, default 16: blank cycles at the start of each slot; legal range 0..PRESCALE-1. Used only with `LEDSCAN_BLANK_EN`.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  one-cycle strobe that stages `num_in`/`dots_in`.
- `num_in`  in  16  value to display; nibble k shows on digit k.
- `dots_in`  in  4  bit k lights the dot on digit k.
- `zero_suppress`  in  1  enables leading-zero blanking.
- `num`  out  16  active display value, to the nibble selector.
- `digit`  out  2  current digit index, to the nibble selector and splitter.
- `dot`  out  1  dot for the current digit, to the segment encoder.
- `blank`  out  1  1 means all digit enables must be forced off.
- `pending`  out  1  staged value not yet committed.
- `frame`  out  1  one-cycle pulse on a commit.

## Operation
- Registers:
  - `slot_cnt`: `$clog2(PRESCALE)` bits.
  - `digit`: 2 bits.
  - active `num` and `dots`.
  - shadow `num` and `dots`.
  - `pending`.
- Slot counter:
  - Counts 0..PRESCALE-1.
  - At PRESCALE-1 it wraps to 0 and `digit` increments modulo 4, so digit 3 is followed by digit 0.
- Load:
  - `load`=1 captures `num_in`/`dots_in` into the shadow registers and sets `pending`.
  - A load while `pending`=1 overwrites the shadow; the latest load wins.
- Commit:
  - Occurs on the edge where `digit` wraps 3→0 and `pending`=1.
  - Active registers take the shadow value, `pending` clears and `frame` pulses.
  - With no pending value, the wrap does not pulse `frame`.
- Load on the commit edge:
  - The commit uses the shadow value held before the edge.
  - The new load is captured into the shadow and `pending` remains 1.
- `dot` = `dots[digit]` from the active registers.
- Suppression:
  - Applies when `zero_suppress`=1, `digit`≠0, and active nibble `digit` and all more-significant nibbles are 0.
  - Digit 0 is never suppressed.
- `blank` = suppression OR the blank window; the blank window is defined in Configuration.
- Reset values (all asynchronous):
  - `num` = 0, `digit` = 0, `dot` = 0, `pending` = 0, `frame` = 0.
  - Shadow registers = 0, `slot_cnt` = 0.
  - `blank` = 1 if `LEDSCAN_BLANK_EN` is defined and BLANK>0, else 0.
- Reset asserted mid-frame discards any pending value. Scanning restarts at digit 0, count 0 on the first edge after release.

## Timing
- All outputs are registered; nothing is combinational from inputs to outputs.
- `load` → `pending`=1: 1 cycle.
- Commit happens at the next 3→0 wrap. Worst-case latency from `load` to new `num` is 4·PRESCALE cycles.
- `digit` changes on the edge where `slot_cnt` goes PRESCALE-1→0. `blank`, `dot` and `num` for the new digit are valid in the same cycle.
- `frame` is high for exactly the one cycle following the commit edge.
- `zero_suppress` is sampled every cycle and takes effect on the next edge.

## Configuration
- Macro: `LEDSCAN_BLANK_EN`.
- Defined:
  - `blank` is also 1 while `slot_cnt` < BLANK.
  - With BLANK=0 there is no window.
  - This removes ghosting while the digit driver switches.
- Undefined:
  - No blank window; `blank` reflects only suppression.
  - The BLANK parameter is ignored and no comparator is synthesised.

## Test plan
Bench runs with PRESCALE=4, BLANK=1.

1. **Reset then scan.** Reset, then `load` `num_in`=16'h1234, `dots_in`=4'b0000, release, run 40 cycles:
   - first commit at the first 3→0 wrap, after 16 cycles;
   - `frame` pulses once;
   - `digit` then sequences 0,1,2,3 with 4 cycles each and `num`=1234.
2. **Double buffer.**
   - Load 16'h66B7 mid-frame while digit=1: `num` stays 1234 until the 3→0 wrap, then becomes 66B7 with one `frame` pulse.
   - `pending`=1 during the wait and 0 afterwards.
3. **Overwrite and collision.**
   - Load 16'hAAAA then 16'h5555 within one frame: only 5555 is committed.
   - Load 16'h1111 exactly on the commit edge: 5555 is committed and `pending` stays 1; 1111 is committed one frame later.
4. **Suppression.**
   - Active 16'h0070 with `zero_suppress`=1: `blank` is high for all of digits 3 and 2, low for digits 1 and 0 apart from window cycles.
   - Active 16'h0000: only digit 0 is unblanked.
5. **Blank window.**
   - With `LEDSCAN_BLANK_EN`: `blank`=1 on `slot_cnt`=0 of every slot.
   - Without it: `blank`=0 throughout for 16'h1234.
6. **Mid-operation reset.** Assert `rst_n`=0 while `pending`=1 at digit 2:
   - immediately `digit`=0, `num`=0, `pending`=0;
   - the staged value is never committed.

Source files
------------

// File: rtl/led_scanner.sv
// Four-digit seven-segment scan controller: double-buffered hex value, slot timing,
// leading-zero suppression. Define LEDSCAN_BLANK_EN to add the anti-ghosting blank window.
module led_scanner #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned BLANK    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] num_in,
    input  logic [3:0]  dots_in,
    input  logic        zero_suppress,
    output logic [15:0] num,
    output logic [1:0]  digit,
    output logic        dot,
    output logic        blank,
    output logic        pending,
    output logic        frame
);

    localparam int unsigned CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);

`ifdef LEDSCAN_BLANK_EN
    localparam logic [CW-1:0] BLANK_W   = CW'(BLANK);
    localparam logic          BLANK_RST = (BLANK > 0);
`else
    localparam logic          BLANK_RST = 1'b0;
`endif

    if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
        $error("led_scanner: PRESCALE must be in 2..65535");
    end
    if (BLANK >= PRESCALE) begin : g_bad_blank
        $error("led_scanner: BLANK must be below PRESCALE");
    end

    logic [CW-1:0] slot_cnt;
    logic [3:0]    dots;
    logic [15:0]   shadow_num;
    logic [3:0]    shadow_dots;

    logic          slot_wrap;
    logic          commit;
    logic [CW-1:0] slot_nxt;
    logic [1:0]    digit_nxt;
    logic [15:0]   num_nxt;
    logic [3:0]    dots_nxt;
    logic          upper_zero;
    logic          window_nxt;

    // Outputs are registered from next-state values so dot/blank/num line up with digit.
    always_comb begin
        slot_wrap = (slot_cnt == SLOT_LAST);
        commit    = slot_wrap && (digit == 2'd3) && pending;
        slot_nxt  = slot_wrap ? '0 : slot_cnt + 1'b1;
        digit_nxt = slot_wrap ? digit + 2'd1 : digit;
        num_nxt   = commit ? shadow_num : num;
        dots_nxt  = commit ? shadow_dots : dots;

        case (digit_nxt)
            2'd1:    upper_zero = (num_nxt[15:4]  == '0);
            2'd2:    upper_zero = (num_nxt[15:8]  == '0);
            2'd3:    upper_zero = (num_nxt[15:12] == '0);
            default: upper_zero = 1'b0;
        endcase

`ifdef LEDSCAN_BLANK_EN
        window_nxt = (slot_nxt < BLANK_W);
`else
        window_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt    <= '0;
            digit       <= '0;
            num         <= '0;
            dots        <= '0;
            shadow_num  <= '0;
            shadow_dots <= '0;
            pending     <= 1'b0;
            frame       <= 1'b0;
            dot         <= 1'b0;
            blank       <= BLANK_RST;
        end else begin
            slot_cnt <= slot_nxt;
            digit    <= digit_nxt;
            num      <= num_nxt;
            dots     <= dots_nxt;
            if (load) begin
                shadow_num  <= num_in;
                shadow_dots <= dots_in;
            end
            // A load on the commit edge keeps pending set for the following frame.
            pending <= load | (pending & ~commit);
            frame   <= commit;
            dot     <= dots_nxt[digit_nxt];
            blank   <= (zero_suppress && upper_zero) || window_nxt;
        end
    end

endmodule

// File: tb/tb_led_scanner.sv
// Scoreboard bench for led_scanner with PRESCALE=4, BLANK=1: timed snapshot queue
// plus a commit queue popped whenever the DUT pulses frame.
module tb_led_scanner;

    localparam int P = 4;
    localparam int B = 1;
`ifdef LEDSCAN_BLANK_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] num_in;
    logic [3:0]  dots_in;
    logic        zero_suppress;
    logic [15:0] num;
    logic [1:0]  digit;
    logic        dot;
    logic        blank;
    logic        pending;
    logic        frame;

    led_scanner #(.PRESCALE(P), .BLANK(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .num_in       (num_in),
        .dots_in      (dots_in),
        .zero_suppress(zero_suppress),
        .num          (num),
        .digit        (digit),
        .dot          (dot),
        .blank        (blank),
        .pending      (pending),
        .frame        (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [1:0]  digit;
        logic [15:0] num;
        logic        pend;
        logic        blank;
        logic        dot;
    } chk_t;

    typedef struct {
        int          cyc;
        logic [15:0] num;
    } frm_t;

    chk_t chk_q[$];
    frm_t frm_q[$];
    int   cyc = 0;
    int   base = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: compares every snapshot due this cycle and every frame pulse.
    always @(negedge clk) begin
        chk_t c;
        frm_t f;
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c = chk_q.pop_front();
            n_checks++;
            if (c.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: snapshot for cycle %0d missed, now %0d", c.name, c.cyc, cyc);
            end else if (digit !== c.digit || num !== c.num || pending !== c.pend ||
                         blank !== c.blank || dot !== c.dot) begin
                n_fail++;
                $display("FAIL %s @%0d: got digit=%0d num=%h pending=%b blank=%b dot=%b, want digit=%0d num=%h pending=%b blank=%b dot=%b",
                         c.name, cyc - base, digit, num, pending, blank, dot,
                         c.digit, c.num, c.pend, c.blank, c.dot);
            end
        end
        if (frame !== 1'b0) begin
            n_checks++;
            if (frm_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame @%0d: got frame=%b num=%h, want frame=0", cyc - base, frame, num);
            end else begin
                f = frm_q.pop_front();
                if (f.cyc != cyc || num !== f.num) begin
                    n_fail++;
                    $display("FAIL commit: got frame at cycle %0d num=%h, want cycle %0d num=%h",
                             cyc, num, f.cyc, f.num);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_to(input int k);
        while (cyc - base < k) tick();
    endtask

    task automatic push_chk(input int abs_cyc, input string name, input logic [1:0] d,
                            input logic [15:0] n, input logic p, input logic b, input logic dt);
        chk_t c;
        c.cyc = abs_cyc; c.name = name; c.digit = d; c.num = n;
        c.pend = p; c.blank = b; c.dot = dt;
        chk_q.push_back(c);
    endtask

    // Expected state after edge k of the scan: supp bit d means digit d is suppressed.
    task automatic snap(input int k, input string name, input logic [15:0] n, input logic p,
                        input logic [3:0] dots, input logic [3:0] supp);
        logic [1:0] d;
        logic       b;
        d = 2'((k / P) % 4);
        b = supp[d] | (WIN_EN && ((k % P) < B));
        push_chk(base + k, name, d, n, p, b, dots[d]);
    endtask

    task automatic push_frm(input int k, input logic [15:0] n);
        frm_t f;
        f.cyc = base + k; f.num = n;
        frm_q.push_back(f);
    endtask

    task automatic load_at(input int k, input logic [15:0] n, input logic [3:0] dts);
        run_to(k - 1);
        load = 1'b1; num_in = n; dots_in = dts;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; load = 1'b0; num_in = '0; dots_in = '0; zero_suppress = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        push_chk(cyc + 1, "reset_state", 2'd0, 16'h0000, 1'b0, WIN_EN, 1'b0);
        tick();

        // 1: reset then scan
        rst_n = 1'b1; base = cyc;
        load = 1'b1; num_in = 16'h1234; dots_in = 4'b0000;
        snap(1, "t1_staged", 16'h0000, 1'b1, 4'h0, 4'h0);
        tick();
        load = 1'b0;
        snap(15, "t1_pre_commit", 16'h0000, 1'b1, 4'h0, 4'h0);
        push_frm(16, 16'h1234);
        for (int k = 16; k < 32; k++) snap(k, "t1_scan", 16'h1234, 1'b0, 4'h0, 4'h0);

        // 2: double buffer
        snap(32, "t2_no_commit", 16'h1234, 1'b0, 4'h0, 4'h0);
        snap(35, "t2_before_load", 16'h1234, 1'b0, 4'h0, 4'h0);
        snap(36, "t2_staged", 16'h1234, 1'b1, 4'h0, 4'h0);
        snap(47, "t2_wait", 16'h1234, 1'b1, 4'h0, 4'h0);
        push_frm(48, 16'h66B7);
        for (int k = 48; k < 60; k += 4) snap(k, "t2_commit", 16'h66B7, 1'b0, 4'b0101, 4'h0);
        load_at(36, 16'h66B7, 4'b0101);

        // 3: overwrite and commit-edge collision
        snap(66, "t3_aaaa_staged", 16'h66B7, 1'b1, 4'b0101, 4'h0);
        snap(79, "t3_pre_commit", 16'h66B7, 1'b1, 4'b0101, 4'h0);
        push_frm(80, 16'h5555);
        snap(80, "t3_commit_5555", 16'h5555, 1'b1, 4'b1010, 4'h0);
        snap(84, "t3_hold_5555", 16'h5555, 1'b1, 4'b1010, 4'h0);
        snap(95, "t3_hold_5555", 16'h5555, 1'b1, 4'b1010, 4'h0);
        push_frm(96, 16'h1111);
        snap(96, "t3_commit_1111", 16'h1111, 1'b0, 4'b1000, 4'h0);
        snap(108, "t3_dot3", 16'h1111, 1'b0, 4'b1000, 4'h0);
        load_at(66, 16'hAAAA, 4'b0000);
        load_at(70, 16'h5555, 4'b1010);
        load_at(80, 16'h1111, 4'b1000);

        // 4: suppression
        snap(127, "t4_no_supp_1111", 16'h1111, 1'b1, 4'b1000, 4'h0);
        push_frm(128, 16'h0070);
        for (int k = 128; k < 144; k++) snap(k, "t4_supp_0070", 16'h0070, 1'b0, 4'b0010, 4'b1100);
        push_frm(160, 16'h0000);
        for (int k = 160; k < 176; k++) snap(k, "t4_supp_0000", 16'h0000, 1'b0, 4'b1111, 4'b1110);
        for (int k = 176; k < 184; k++) snap(k, "t4_supp_off", 16'h0000, 1'b0, 4'b1111, 4'h0);
        load_at(113, 16'h0070, 4'b0010);
        run_to(119);
        zero_suppress = 1'b1;
        load_at(145, 16'h0000, 4'b1111);
        run_to(175);
        zero_suppress = 1'b0;

        // 5: blank window over a full frame
        push_frm(192, 16'h1234);
        for (int k = 192; k < 208; k++) snap(k, "t5_window", 16'h1234, 1'b0, 4'h0, 4'h0);
        load_at(185, 16'h1234, 4'h0);

        // 6: reset mid-frame with a value pending
        snap(216, "t6_pending_d2", 16'h1234, 1'b1, 4'h0, 4'h0);
        push_chk(base + 218, "t6_reset", 2'd0, 16'h0000, 1'b0, WIN_EN, 1'b0);
        push_chk(base + 219, "t6_reset_hold", 2'd0, 16'h0000, 1'b0, WIN_EN, 1'b0);
        load_at(209, 16'hABCD, 4'b1111);
        run_to(217);
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1; base = cyc;
        snap(1, "t6_restart", 16'h0000, 1'b0, 4'h0, 4'h0);
        snap(16, "t6_no_commit", 16'h0000, 1'b0, 4'h0, 4'h0);
        snap(33, "t6_no_commit", 16'h0000, 1'b0, 4'h0, 4'h0);
        run_to(44);
        tick();

        n_checks++;
        if (chk_q.size() != 0) begin
            n_fail++;
            $display("FAIL snapshots_drained: got %0d left, want 0", chk_q.size());
        end
        n_checks++;
        if (frm_q.size() != 0) begin
            n_fail++;
            $display("FAIL commits_drained: got %0d missing frames, want 0", frm_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
